// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared pipeline constants, 2-bit counter encodings and BTB entry layout
package cpu_pkg;

  localparam int XLEN = 32;
  // Widest tag a legal table can need (ENTRIES=2); smaller tags are zero-extended into it.
  localparam int TAG_MAX_W = XLEN - 3;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic [XLEN-1:0]      target;
    logic                 is_jmp;
    logic [1:0]           ctr;
  } btb_entry_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// rtl/bp_sat_ctr.sv - 2-bit saturating bimodal counter next-state function
module bp_sat_ctr
  import cpu_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       taken_i,
  output logic [1:0] ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (taken_i) begin
      if (ctr_i != ST) ctr_o = ctr_i + 2'b01;
    end else begin
      if (ctr_i != SNT) ctr_o = ctr_i - 2'b01;
    end
  end

endmodule

// File: rtl/bp_btb.sv
// rtl/bp_btb.sv - direct-mapped branch target buffer with bimodal prediction and EX-stage training
module bp_btb
  import cpu_pkg::*;
#(
  parameter int         XLEN     = cpu_pkg::XLEN,
  parameter int         ENTRIES  = 16,
  parameter logic [1:0] CTR_INIT = 2'b01
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  logic            ex_is_br,
  input  logic            ex_is_jmp,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     br_cnt,
  output logic [31:0]     mispred_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - 2 - IDX_W;

  localparam btb_entry_t RST_ENT = '{valid: 1'b0, tag: '0, target: '0, is_jmp: 1'b0, ctr: CTR_INIT};

  btb_entry_t tbl_q [ENTRIES];
  btb_entry_t tbl_d [ENTRIES];
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] mispred_cnt_q, mispred_cnt_d;

  logic [IDX_W-1:0]     if_idx, ex_idx;
  logic [TAG_MAX_W-1:0] if_tag, ex_tag;
  btb_entry_t           if_ent, ex_ent, alloc_ent;
  logic                 if_hit, ex_hit, ex_act, ex_cf;
  logic [XLEN-1:0]      ex_pc_inc;
  logic [1:0]           ctr_next;

  // IF lookup: reads only the registered table, so same-cycle training is not bypassed.
  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = TAG_MAX_W'(if_pc[XLEN-1:IDX_W+2]);
  assign if_ent = tbl_q[if_idx];
  assign if_hit = if_ent.valid & (if_ent.tag == if_tag);

  assign pred_taken  = ~rst & if_hit & (if_ent.is_jmp | (if_ent.ctr >= WT));
  assign pred_target = pred_taken ? if_ent.target : if_pc + XLEN'(4);

  assign ex_idx    = ex_pc[IDX_W+1:2];
  assign ex_tag    = TAG_MAX_W'(ex_pc[XLEN-1:IDX_W+2]);
  assign ex_ent    = tbl_q[ex_idx];
  assign ex_hit    = ex_ent.valid & (ex_ent.tag == ex_tag);
  assign ex_act    = ex_valid & ~rst;
  assign ex_cf     = ex_is_br | ex_is_jmp;
  assign ex_pc_inc = ex_pc + XLEN'(4);

  // A non-control-flow instruction predicted taken came from a stale entry and must be undone.
  always_comb begin
    mispredict  = 1'b0;
    redirect_pc = '0;
    if (!rst) begin
      redirect_pc = (ex_cf & ex_taken) ? ex_target : ex_pc_inc;
      if (ex_valid) begin
        if (ex_cf)
          mispredict = (ex_taken != ex_pred_taken) |
                       (ex_taken & ex_pred_taken & (ex_pred_target != ex_target));
        else
          mispredict = ex_pred_taken;
      end
    end
  end

  bp_sat_ctr u_sat_ctr (
    .ctr_i   (ex_ent.ctr),
    .taken_i (ex_taken),
    .ctr_o   (ctr_next)
  );

  assign alloc_ent = '{valid: 1'b1, tag: ex_tag, target: ex_target, is_jmp: ex_is_jmp, ctr: WT};

  always_comb begin
    tbl_d         = tbl_q;
    br_cnt_d      = br_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (ex_act) begin
      if (ex_hit) begin
        if (ex_is_jmp) begin
          tbl_d[ex_idx].target = ex_target;
          tbl_d[ex_idx].is_jmp = 1'b1;
        end else if (ex_is_br) begin
          tbl_d[ex_idx].ctr = ctr_next;
          if (ex_taken) tbl_d[ex_idx].target = ex_target;
        end else begin
          tbl_d[ex_idx].valid = 1'b0;
        end
      end else if (ex_cf & ex_taken) begin
        tbl_d[ex_idx] = alloc_ent;
      end
      if (ex_cf)      br_cnt_d      = sat_inc32(br_cnt_q);
      if (mispredict) mispred_cnt_d = sat_inc32(mispred_cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) tbl_q[i] <= RST_ENT;
      br_cnt_q      <= '0;
      mispred_cnt_q <= '0;
    end else begin
      tbl_q         <= tbl_d;
      br_cnt_q      <= br_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign br_cnt      = br_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_bp_btb.sv
// tb/tb_bp_btb.sv - randomized self-checking bench for bp_btb against a table-level reference model
module tb_bp_btb;

  localparam int ENT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid, ex_is_br, ex_is_jmp, ex_taken, ex_pred_taken;
  logic [31:0] ex_pc, ex_target, ex_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc, br_cnt, mispred_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  bit          m_valid  [ENT];
  int unsigned m_tag    [ENT];
  logic [31:0] m_tgt    [ENT];
  bit          m_jmp    [ENT];
  int          m_ctr    [ENT];
  logic [31:0] m_br, m_mis;

  bp_btb #(.XLEN(32), .ENTRIES(ENT), .CTR_INIT(2'b01)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_is_br(ex_is_br), .ex_is_jmp(ex_is_jmp), .ex_pc(ex_pc),
    .ex_taken(ex_taken), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .mispredict(mispredict), .redirect_pc(redirect_pc),
    .br_cnt(br_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc / 4) % ENT);
  endfunction

  function automatic int unsigned m_tagof(input logic [31:0] pc);
    return pc / (4 * ENT);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == m_tagof(pc));
  endfunction

  task automatic m_reset();
    for (int i = 0; i < ENT; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_jmp[i] = 0; m_ctr[i] = 1;
    end
    m_br = 0; m_mis = 0;
  endtask

  task automatic m_lookup(input logic [31:0] pc, output bit t, output logic [31:0] g);
    int i;
    i = m_idx(pc);
    t = m_hit(pc) && (m_jmp[i] || m_ctr[i] >= 2);
    g = t ? m_tgt[i] : pc + 32'd4;
  endtask

  task automatic m_update(input bit br, jmp, input logic [31:0] pc, input bit tk,
                          input logic [31:0] tg, input bit mis);
    int i;
    i = m_idx(pc);
    if (m_hit(pc)) begin
      if (jmp) begin
        m_tgt[i] = tg; m_jmp[i] = 1;
      end else if (br) begin
        m_ctr[i] = tk ? ((m_ctr[i] == 3) ? 3 : m_ctr[i] + 1) : ((m_ctr[i] == 0) ? 0 : m_ctr[i] - 1);
        if (tk) m_tgt[i] = tg;
      end else begin
        m_valid[i] = 0;
      end
    end else if ((br || jmp) && tk) begin
      m_valid[i] = 1; m_tag[i] = m_tagof(pc); m_tgt[i] = tg; m_jmp[i] = jmp; m_ctr[i] = 2;
    end
    if ((br || jmp) && m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
    if (mis && m_mis != 32'hFFFF_FFFF) m_mis = m_mis + 1;
  endtask

  // One clock: drive at negedge, check combinational outputs and counters mid-cycle, then retire.
  task automatic cycle(input bit r, v, br, jmp, input logic [31:0] pc, input bit tk,
                       input logic [31:0] tg, input bit ppt, input logic [31:0] ppg,
                       input logic [31:0] lpc);
    bit          e_pt, e_mis, cf;
    logic [31:0] e_pg, e_rd;
    @(negedge clk);
    rst = r; ex_valid = v; ex_is_br = br; ex_is_jmp = jmp; ex_pc = pc; ex_taken = tk;
    ex_target = tg; ex_pred_taken = ppt; ex_pred_target = ppg; if_pc = lpc;
    #1;
    cf = br || jmp;
    if (r) begin
      e_pt = 0; e_pg = lpc + 32'd4; e_mis = 0; e_rd = 0;
    end else begin
      m_lookup(lpc, e_pt, e_pg);
      e_mis = v && (cf ? ((tk != ppt) || (tk && ppt && ppg != tg)) : ppt);
      e_rd  = (cf && tk) ? tg : pc + 32'd4;
    end
    n_checks += 6;
    if (pred_taken !== e_pt) begin
      n_fail++; $display("FAIL pred_taken pc=%h: got %b expected %b", lpc, pred_taken, e_pt);
    end
    if (pred_target !== e_pg) begin
      n_fail++; $display("FAIL pred_target pc=%h: got %h expected %h", lpc, pred_target, e_pg);
    end
    if (mispredict !== e_mis) begin
      n_fail++; $display("FAIL mispredict ex_pc=%h: got %b expected %b", pc, mispredict, e_mis);
    end
    if (redirect_pc !== e_rd) begin
      n_fail++; $display("FAIL redirect_pc ex_pc=%h: got %h expected %h", pc, redirect_pc, e_rd);
    end
    if (br_cnt !== m_br) begin
      n_fail++; $display("FAIL br_cnt: got %0d expected %0d", br_cnt, m_br);
    end
    if (mispred_cnt !== m_mis) begin
      n_fail++; $display("FAIL mispred_cnt: got %0d expected %0d", mispred_cnt, m_mis);
    end
    if (r) m_reset();
    else if (v) m_update(br, jmp, pc, tk, tg, e_mis);
    @(posedge clk);
  endtask

  task automatic idle(input logic [31:0] lpc);
    cycle(0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, lpc);
  endtask

  task automatic test_reset();
    // Reset held with a live mispredicting EX op: outputs must stay quiet and nothing may count.
    cycle(1, 1, 1, 0, 32'h40, 1, 32'h80, 0, 32'h0, 32'h40);
    cycle(1, 1, 0, 1, 32'h10, 1, 32'h99c, 1, 32'h0, 32'h44);
    idle(32'h40);
    idle(32'hFFFF_FFFC);
  endtask

  task automatic test_branch_train();
    cycle(0, 1, 1, 0, 32'h40, 1, 32'h80, 0, 32'h44, 32'h40);
    idle(32'h40);
    cycle(0, 1, 1, 0, 32'h40, 0, 32'h0, 1, 32'h80, 32'h40);
    idle(32'h40);
    cycle(0, 1, 1, 0, 32'h40, 0, 32'h0, 0, 32'h44, 32'h40);
    idle(32'h40);
    cycle(0, 1, 1, 0, 32'h40, 0, 32'h0, 0, 32'h44, 32'h40);
    cycle(0, 1, 1, 0, 32'h40, 1, 32'h84, 0, 32'h44, 32'h40);
    cycle(0, 1, 1, 0, 32'h40, 1, 32'h84, 0, 32'h44, 32'h40);
    idle(32'h40);
  endtask

  task automatic test_alias();
    idle(32'h80);
    cycle(0, 1, 1, 0, 32'h80, 1, 32'h300, 0, 32'h84, 32'h80);
    idle(32'h40);
    idle(32'h80);
  endtask

  task automatic test_jump();
    cycle(0, 1, 0, 1, 32'h100, 1, 32'h200, 1, 32'h204, 32'h100);
    idle(32'h100);
    cycle(0, 1, 1, 0, 32'h100, 0, 32'h0, 1, 32'h200, 32'h100);
    cycle(0, 1, 1, 0, 32'h100, 0, 32'h0, 0, 32'h104, 32'h100);
    idle(32'h100);
    cycle(0, 1, 0, 0, 32'h100, 0, 32'h0, 1, 32'h200, 32'h100);
    idle(32'h100);
    cycle(0, 1, 0, 1, 32'hFFFF_FFFC, 1, 32'h8, 0, 32'h0, 32'hFFFF_FFFC);
    idle(32'hFFFF_FFFC);
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      logic [31:0] pc, tg, ppg, lpc;
      bit br, jmp, tk, ppt, v;
      int kind;
      pc   = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
      lpc  = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
      tg   = $urandom & 32'hFFFF_FFFC;
      kind = $urandom_range(0, 2);
      v    = ($urandom_range(0, 9) != 0);
      br   = (kind == 1); jmp = (kind == 2);
      tk   = jmp || (br && $urandom_range(0, 1));
      if ($urandom_range(0, 9) < 7) m_lookup(pc, ppt, ppg);
      else begin ppt = $urandom_range(0, 1); ppg = $urandom & 32'hFFFF_FFFC; end
      if (tk && $urandom_range(0, 3) == 0 && m_hit(pc)) tg = m_tgt[m_idx(pc)];
      cycle(0, v, br, jmp, pc, tk, tg, ppt, ppg, lpc);
    end
  endtask

  task automatic test_back_to_back_reset();
    for (int i = 0; i < 16; i++)
      cycle(0, 1, i[0], !i[0], 32'h200 + 32'(i * 4), 1, 32'h1000 + 32'(i * 8), 0, 32'h0, 32'h200);
    cycle(1, 1, 1, 0, 32'h204, 1, 32'h4444, 0, 32'h0, 32'h204);
    for (int i = 0; i < 16; i++) idle(32'h200 + 32'(i * 4));
  endtask

  initial begin
    rst = 1; if_pc = 0; ex_valid = 0; ex_is_br = 0; ex_is_jmp = 0; ex_pc = 0;
    ex_taken = 0; ex_target = 0; ex_pred_taken = 0; ex_pred_target = 0;
    m_reset();
    test_reset();
    test_branch_train();
    test_alias();
    test_jump();
    test_random();
    test_back_to_back_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
